// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states and baud divisors.
// Imported by the UART TX arbiter and its round-robin picker.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_STROBE    = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  localparam int BPS_9600   = 325;
  localparam int BPS_115200 = 27;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, cyclically.
// Ports: req (requests), ptr (start index) -> gnt (one-hot), idx (index).
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  int j;

  // Scan from the far end so the nearest match to ptr is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one uart_tx among N_REQ
// byte streams. Ports: req_* (requesters), tx_* (uart_tx), grant/busy/timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int START_TO = 64,
  parameter int FRAME_TO = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               tx_idle,
  output logic               tx_wrsig,
  output logic [7:0]         tx_data,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               timeout_err
);

  localparam int CMAX =
    (START_TO > FRAME_TO) ? START_TO : FRAME_TO;
  localparam int CW = $clog2(CMAX + 1);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           st_q, st_d;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    g_q, g_d, g_next;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic [7:0]       tx_data_q;
  logic             last_q;
  logic             take;
  logic             done;
  logic             frame_exp;
  logic             start_exp;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign g_next = (g_q == PW'(N_REQ - 1)) ?
                  '0 : g_q + PW'(1);

  assign take = (st_q == ST_LOAD) &
                req_valid[g_q] & tx_idle;

  assign frame_exp = cnt_q >= CW'(FRAME_TO - 1);
  assign start_exp = cnt_q >= CW'(START_TO - 1);

  always_comb begin
    st_d        = st_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    req_ready   = '0;
    tx_wrsig    = 1'b0;
    timeout_err = 1'b0;
    done        = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_d = pick_gnt;
          g_d     = pick_idx;
          st_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (take) begin
          req_ready = grant_q;
          st_d      = ST_STROBE;
        end else if (frame_exp) begin
          // Stalled owner loses the frame; next contest starts after it.
          timeout_err = 1'b1;
          grant_d     = '0;
          ptr_d       = g_next;
          st_d        = ST_IDLE;
        end
      end
      ST_STROBE: begin
        tx_wrsig = 1'b1;
        st_d     = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!tx_idle) begin
          st_d = ST_WAIT_IDLE;
        end else if (start_exp) begin
          // uart_tx never started: count the byte as sent.
          timeout_err = 1'b1;
          done        = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (tx_idle) done = 1'b1;
      end
      default: st_d = ST_IDLE;
    endcase
    if (done) begin
      if (last_q) begin
        grant_d = '0;
        ptr_d   = g_next;
        st_d    = ST_IDLE;
      end else begin
        st_d = ST_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      g_q       <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
      last_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      grant_q <= grant_d;
      // One counter serves both timeouts; it restarts on every state change.
      if (st_d != st_q)
        cnt_q <= '0;
      else if (cnt_q != CW'(CMAX))
        cnt_q <= cnt_q + CW'(1);
      if (take) begin
        tx_data_q <= req_data[8*int'(g_q) +: 8];
        last_q    <= req_last[g_q];
      end
    end
  end

  assign grant   = grant_q;
  assign tx_data = tx_data_q;
  assign busy    = (st_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple uart_tx timing model.
// Directed frames; a monitor checks every write strobe against a queue.
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int ST = 16;
  localparam int FT = 200;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          tx_idle;
  logic          tx_wrsig;
  logic [7:0]    tx_data;
  logic [N-1:0]  grant;
  logic          busy;
  logic          timeout_err;

  uart_tx_arbiter #(
    .N_REQ    (N),
    .START_TO (ST),
    .FRAME_TO (FT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_idle     (tx_idle),
    .tx_wrsig    (tx_wrsig),
    .tx_data     (tx_data),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int to_cnt = 0;
  int to_exp = 0;
  bit stuck = 1'b0;

  // requester queues: {last, data}; scoreboard: {id, data}
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] sb[$];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  // uart_tx model: idle falls 2 cycles after wrsig, low 160 cycles
  initial begin
    int dly, lowc;
    tx_idle = 1'b1;
    dly = 0;
    lowc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || stuck) begin
        tx_idle = 1'b1;
        dly = 0;
        lowc = 0;
      end else begin
        if (lowc > 0) begin
          lowc--;
          if (lowc == 0) tx_idle = 1'b1;
        end
        if (dly > 0) begin
          dly--;
          if (dly == 0) begin
            tx_idle = 1'b0;
            lowc = 160;
          end
        end
        if (tx_wrsig) dly = 2;
      end
    end
  end

  // requester drivers
  initial begin
    logic [N-1:0] pend;
    logic [8:0] e;
    pend = '0;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend = '0;
      if (pend[0] && q0.size() > 0) e = q0.pop_front();
      if (pend[1] && q1.size() > 0) e = q1.pop_front();
      req_valid = '0;
      req_data = '0;
      req_last = '0;
      if (q0.size() > 0) begin
        req_valid[0] = 1'b1;
        e = q0[0];
        req_last[0] = e[8];
        req_data[7:0] = e[7:0];
      end
      if (q1.size() > 0) begin
        req_valid[1] = 1'b1;
        e = q1[0];
        req_last[1] = e[8];
        req_data[15:8] = e[7:0];
      end
      #1;
      pend = req_ready;
    end
  end

  // monitor
  initial begin
    bit prev_wr;
    logic [8:0] e;
    logic [N-1:0] og;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (tx_wrsig) begin
        chk("wrsig_gap", int'(prev_wr), 0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_wr data=%0h", tx_data);
        end else begin
          e = sb.pop_front();
          og = '0;
          og[e[8]] = 1'b1;
          chk("tx_data", int'(tx_data), int'(e[7:0]));
          chk("wr_grant", int'(grant), int'(og));
        end
      end
      if (req_ready != '0)
        chk("ready_owner", int'(req_ready & ~grant), 0);
      if (timeout_err) to_cnt++;
      prev_wr = tx_wrsig;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_grant"}, int'(grant), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_wrsig"}, int'(tx_wrsig), 0);
    chk({nm, "_ready"}, int'(req_ready), 0);
    chk({nm, "_to"}, int'(timeout_err), 0);
    chk({nm, "_txdata"}, int'(tx_data), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    cyc(2);
    check_zero("rst");
    rst_n = 1'b1;
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 ||
            sb.size() != 0 || busy) && n < budget) begin
      cyc(1);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_drain act=%0d req=<%0d cycles", nm, n, budget);
    end
    cyc(3);
    chk({nm, "_grant_end"}, int'(grant), 0);
    chk({nm, "_timeouts"}, to_cnt, to_exp);
  endtask

  task automatic wait_sb(input int sz, input int budget);
    int n;
    n = 0;
    while (sb.size() > sz && n < budget) begin
      cyc(1);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL wait_sb act=%0d req=%0d", sb.size(), sz);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cyc(3);
    do_reset();

    // 1: "AT\r\n" from req0
    q0.push_back(9'h041); q0.push_back(9'h054);
    q0.push_back(9'h00D); q0.push_back(9'h10A);
    sb.push_back(9'h041); sb.push_back(9'h054);
    sb.push_back(9'h00D); sb.push_back(9'h00A);
    drain("t1", 3000);

    // 2: contest right after reset -> req0 first
    do_reset();
    q0.push_back(9'h010); q0.push_back(9'h111);
    q1.push_back(9'h020); q1.push_back(9'h121);
    sb.push_back(9'h010); sb.push_back(9'h011);
    sb.push_back(9'h120); sb.push_back(9'h121);
    drain("t2a", 3000);
    q0.push_back(9'h130);
    sb.push_back(9'h030);
    drain("t2b", 1000);
    // ptr now 1: req1 wins the contest
    q0.push_back(9'h140);
    q1.push_back(9'h150);
    sb.push_back(9'h150); sb.push_back(9'h040);
    drain("t2c", 1000);

    // 3: req1 arrives mid req0 frame
    q0.push_back(9'h060); q0.push_back(9'h061);
    q0.push_back(9'h062); q0.push_back(9'h163);
    sb.push_back(9'h060); sb.push_back(9'h061);
    sb.push_back(9'h062); sb.push_back(9'h063);
    sb.push_back(9'h170); sb.push_back(9'h171);
    wait_sb(5, 500);
    q1.push_back(9'h070); q1.push_back(9'h171);
    drain("t3", 3000);

    // 4: owner stalls after 2 bytes -> frame timeout, req1 served
    q0.push_back(9'h080); q0.push_back(9'h081);
    q1.push_back(9'h190);
    sb.push_back(9'h080); sb.push_back(9'h081);
    sb.push_back(9'h190);
    to_exp += 1;
    drain("t4", 3000);

    // 5: uart never goes busy -> start timeout per byte
    stuck = 1'b1;
    q0.push_back(9'h0A0); q0.push_back(9'h1A1);
    sb.push_back(9'h0A0); sb.push_back(9'h0A1);
    to_exp += 2;
    drain("t5", 500);
    stuck = 1'b0;

    // 6: reset while waiting for uart idle
    q0.push_back(9'h0B0); q0.push_back(9'h0B1);
    q0.push_back(9'h1B2);
    sb.push_back(9'h0B0);
    wait_sb(0, 500);
    cyc(20);
    chk("t6_busy", int'(busy), 1);
    do_reset();
    q0.push_back(9'h1C0);
    q1.push_back(9'h1C1);
    sb.push_back(9'h0C0); sb.push_back(9'h1C1);
    drain("t6", 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
